// File: rtl/relu_maxpool2x2_pkg.sv
// -----------------------------------------------------------------------------
// pool_pkg
// Shared definitions for the relu_maxpool2x2 pooling stage: sample width,
// the row-phase state encoding and a signed 16-bit max helper.
// -----------------------------------------------------------------------------
package pool_pkg;

   localparam int DATA_W = 16;

   typedef enum logic [1:0] {
      ROW_EVEN = 2'd0,  // first row of a 2x2 block: build pair maxima
      ROW_ODD  = 2'd1,  // second row of a block: finish and emit
      DROP     = 2'd2   // unpaired last row of an odd-height frame
   } state_t;

   // Signed two's-complement max; ties return either operand (equal anyway).
   function automatic logic signed [DATA_W-1:0] smax16(
      input logic signed [DATA_W-1:0] a,
      input logic signed [DATA_W-1:0] b
   );
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/relu_maxpool2x2_if.sv
// -----------------------------------------------------------------------------
// relu_maxpool2x2_if
// Streaming bus between the convolution stage and the pooling stage.
//   conv_valid / conv_out : sample stream into the pooler (raster order)
//   pool_valid / pool_out : pooled result strobe and value
//   frame_done            : strobe after the last sample of a frame
// Modports: master = upstream/consumer side, slave = pooling stage.
// -----------------------------------------------------------------------------
interface relu_maxpool2x2_if;
   import pool_pkg::*;

   logic                     conv_valid;
   logic signed [DATA_W-1:0] conv_out;
   logic signed [DATA_W-1:0] pool_out;
   logic                     pool_valid;
   logic                     frame_done;

   modport master (
      output conv_valid, conv_out,
      input  pool_out, pool_valid, frame_done
   );

   modport slave (
      input  conv_valid, conv_out,
      output pool_out, pool_valid, frame_done
   );

endinterface

// File: rtl/relu_maxpool2x2_row_buf.sv
// -----------------------------------------------------------------------------
// pool_row_buf
// Half-row buffer of pair maxima. One write port, asynchronous read, both
// addressed by the same index (col>>1).
//   clk   : clock
//   we    : write enable
//   idx   : entry index
//   wdata : value written on we
//   rdata : combinational read of entry idx
// -----------------------------------------------------------------------------
module pool_row_buf
   import pool_pkg::*;
#(
   parameter int DEPTH = 15,
   parameter int IDX_W = 4
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [IDX_W-1:0]         idx,
   input  logic signed [DATA_W-1:0] wdata,
   output logic signed [DATA_W-1:0] rdata
);

   logic signed [DATA_W-1:0] mem [0:DEPTH-1];

   // NOTE: storage is deliberately not reset; every entry is rewritten in an
   // even row before any odd row reads it, so a reset would only cost area.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[idx] <= wdata;
      end
   end

   assign rdata = mem[idx];

endmodule

// File: rtl/relu_maxpool2x2.sv
// -----------------------------------------------------------------------------
// relu_maxpool2x2
// Streaming 2x2 stride-2 max-pool over a raster-order convolution stream,
// with optional per-sample ReLU. Odd trailing columns/rows are dropped.
// One pooled value is emitted per 2x2 block; there is no backpressure.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : relu_maxpool2x2_if.slave (conv_valid/conv_out in,
//         pool_valid/pool_out/frame_done out)
// Parameters: CONV_W, CONV_H = convolution output frame size (each >= 2).
// Build option: define POOL_RELU_EN to clamp negative samples to 0 before max.
// -----------------------------------------------------------------------------
module relu_maxpool2x2
   import pool_pkg::*;
#(
   parameter int CONV_W = 30,
   parameter int CONV_H = 30
) (
   input  logic              clk,
   input  logic              rst,
   relu_maxpool2x2_if.slave  bus
);

   localparam int  DEPTH = CONV_W / 2;
   localparam int  IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int  COL_W = $clog2(CONV_W);
   localparam int  ROW_W = $clog2(CONV_H);
   localparam bit  H_ODD = (CONV_H % 2) == 1;

   state_t                   state_q, state_d;
   logic [COL_W-1:0]         col;
   logic [ROW_W-1:0]         row;
   logic signed [DATA_W-1:0] hold;
   logic signed [DATA_W-1:0] s;
   logic signed [DATA_W-1:0] pair_max;
   logic signed [DATA_W-1:0] quad_max;
   logic signed [DATA_W-1:0] buf_rdata;
   logic signed [DATA_W-1:0] pool_out_q;
   logic                     pool_valid_q;
   logic                     frame_done_q;
   logic [IDX_W-1:0]         buf_idx;
   logic                     row_end, last_row, frame_end, next_row_last;
   logic                     buf_we, emit;

`ifdef POOL_RELU_EN
   assign s = bus.conv_out[DATA_W-1] ? '0 : bus.conv_out;
`else
   assign s = bus.conv_out;
`endif

   assign row_end       = (col == COL_W'(CONV_W - 1));
   assign last_row      = (row == ROW_W'(CONV_H - 1));
   assign frame_end     = row_end && last_row;
   assign next_row_last = (row == ROW_W'(CONV_H - 2));

   assign buf_idx  = IDX_W'(col >> 1);
   assign pair_max = smax16(hold, s);
   assign quad_max = smax16(pair_max, buf_rdata);

   pool_row_buf #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_row_buf (
      .clk   (clk),
      .we    (buf_we),
      .idx   (buf_idx),
      .wdata (pair_max),
      .rdata (buf_rdata)
   );

   // NOTE: every signal assigned here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      buf_we  = 1'b0;
      emit    = 1'b0;
      if (bus.conv_valid) begin
         // Odd columns complete a horizontal pair; the trailing even column
         // of an odd-width row never pairs and so writes/emits nothing.
         buf_we = (state_q == ROW_EVEN) && col[0];
         emit   = (state_q == ROW_ODD)  && col[0];
         if (frame_end) begin
            state_d = ROW_EVEN;
         end else if (row_end) begin
            unique case (state_q)
               ROW_EVEN: state_d = ROW_ODD;
               ROW_ODD:  state_d = (H_ODD && next_row_last) ? DROP : ROW_EVEN;
               DROP:     state_d = DROP;
               default:  state_d = ROW_EVEN;
            endcase
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ROW_EVEN;
         col          <= '0;
         row          <= '0;
         hold         <= '0;
         pool_out_q   <= '0;
         pool_valid_q <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         pool_valid_q <= emit;
         frame_done_q <= bus.conv_valid && frame_end;
         if (emit) begin
            pool_out_q <= quad_max;
         end
         if (bus.conv_valid) begin
            state_q <= state_d;
            if (!col[0] && state_q != DROP) begin
               hold <= s;
            end
            if (row_end) begin
               col <= '0;
               row <= last_row ? '0 : row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
         end
      end
   end

   assign bus.pool_out   = pool_out_q;
   assign bus.pool_valid = pool_valid_q;
   assign bus.frame_done = frame_done_q;

endmodule
